fp_result_drain: RTL and testbench
==================================

// Module: fp_result_drain
// PURPOSE
//  Sits directly downstream of the filter pipeline (fp). It buffers the per-lane result
//  bit vectors in small per-lane FIFOs, arbitrates round-robin across lanes, and serialises
//  each vector into matching IDs, one set-bit index per cycle, over a valid/ready handshake.
//  The output feeds the ID consumer (result writer / host egress).
// PARAMETERS
//  BIT_VEC_SIZE      128  width of one result bit vector (one bit per ID)
//  BIT_VEC_SIZE_LOG  7    log2(BIT_VEC_SIZE); width of an ID
//  INPUTS            2    number of fp output lanes
//  FIFO_DEPTH        4    vectors buffered per lane (power of 2, >=2)
//  LANE_W            (INPUTS>1 ? $clog2(INPUTS) : 1)  lane index width (derived)
// PORTS
//  clk        in   1                    clock; all state on posedge
//  rst        in   1                    asynchronous, active-low reset
//  in         in   BIT_VEC_SIZE x INPUTS   result vectors from fp out[]
//  valid_in   in   1 x INPUTS           per-lane vector strobe from fp valid_out[]
//  id_out     out  BIT_VEC_SIZE_LOG     matching ID (bit index)
//  lane_out   out  LANE_W               lane the current vector came from
//  last_out   out  1                    id_out is the final set bit of its vector
//  valid_out  out  1                    id_out/lane_out/last_out valid
//  ready_in   in   1                    consumer accepts on valid_out && ready_in
//  overflow   out  1                    sticky: a vector was dropped on a full FIFO
//  busy       out  1                    any FIFO non-empty or engine in EMIT
// BEHAVIOUR
//  - Reset (rst=0, async): all FIFOs empty, state IDLE, rr pointer 0, W=0; valid_out,
//    id_out, lane_out, last_out, overflow, busy = 0 (and count_out/count_valid = 0).
//  - Lane FIFO write: valid_in[l] sampled each edge; accepted if FIFO l not full, or if it is
//    full and is popped on the same edge. Otherwise the vector is dropped and overflow <= 1
//    (held until reset). fp has no backpressure; there is no in_ready.
//  - Engine FSM, 2 states:
//    IDLE: if any FIFO non-empty, select first non-empty lane at or after rr pointer
//      (wrapping), pop its head into working register W, latch lane, rr <= lane+1 (mod
//      INPUTS), go EMIT. Otherwise stay.
//    EMIT: W==0 (all-zero vector): discard, no output, go IDLE (1 cycle).
//      Else valid_out=1, id_out=index of lowest set bit of W, last_out=(W has one bit set).
//      On valid_out&&ready_in: clear that bit in W; if last_out, go IDLE.
//  - Outputs are decoded from registered W/lane only; while valid_out && !ready_in, id_out,
//    lane_out, last_out are held stable, and valid_out is never withdrawn.
//  - Latency: vector sampled at edge t into an empty FIFO with the engine IDLE yields the
//    first valid_out in the cycle after edge t+1. That is 2 cycles.
//  - Throughput: 1 ID/cycle while ready_in=1. There is one IDLE bubble between vectors.
//  - Ordering: per lane strictly FIFO. Across lanes, round-robin per vector (not per ID).
//  - Bit 0 is emitted first and bit BIT_VEC_SIZE-1 last. A vector with only bit
//    BIT_VEC_SIZE-1 set emits id=BIT_VEC_SIZE-1 with last_out=1.
//  - Reset mid-EMIT: the partial vector and all buffered vectors are lost, with no residual
//    output after release.
// CONFIGURATION
//  FP_DRAIN_COUNT_EN defined:
//   - Adds ports count_out (out, BIT_VEC_SIZE_LOG+1) and count_valid (out, 1).
//   - On the pop into W, count_out <= popcount of the popped vector.
//   - count_valid pulses high for 1 cycle when that vector finishes: either the handshake
//     with last_out=1, or the EMIT cycle that discards a zero vector.
//   - Full vector gives count_out = BIT_VEC_SIZE.
//  FP_DRAIN_COUNT_EN undefined: ports and popcount logic are absent; all other behaviour
//  is identical.
// TESTING (BIT_VEC_SIZE=128, INPUTS=2, FIFO_DEPTH=4 unless noted)
//  1. Lane0 vector 0x112 (bits 1,4,8), ready_in=1 -> ids 1,4,8 on 3 consecutive cycles,
//     starting 2 cycles after the strobe; lane_out=0; last_out only with id 8.
//  2. Same-cycle lane0={bit127}, lane1={bit0}, rr=0 -> id 127 lane 0 last, 1 bubble,
//     then id 0 lane 1 last; rr then starts at lane 0 again.
//  3. Backpressure: vector 0x6, ready_in=0 for 3 cycles then 1 -> id 1 held stable 3 cycles,
//     then ids 1,2 delivered; no ID lost or duplicated.
//  4. Overflow: ready_in=0, 6 lane0 vectors on consecutive cycles -> 1 in W, 4 buffered,
//     6th dropped, overflow=1 and stays 1; exactly 5 vectors drain after ready_in=1.
//  5. Lane1 all-zero vector then vector 0x1 -> no output for the zero vector, then id 0
//     last. With FP_DRAIN_COUNT_EN: count_out=0 then 1; then an all-ones vector -> 128.
//  6. rst low during EMIT of 0xF0 after 1 accepted ID -> valid_out=0, busy=0, overflow=0
//     immediately; after release with no new input, valid_out stays 0 for 10 cycles.

Source files
------------

// File: rtl/fp_result_drain_if.sv
// fp_result_drain_if: signal bundle between the fp lanes, the drain engine and the ID consumer.
// Ports (master = drain engine, slave = its environment):
//   in/valid_in         per-lane result vectors and strobes from fp
//   id_out/lane_out/last_out/valid_out, ready_in   ID stream handshake to the consumer
//   overflow/busy       status
//   count_out/count_valid  per-vector popcount report, present only with FP_DRAIN_COUNT_EN
interface fp_result_drain_if #(
  parameter int BIT_VEC_SIZE = 128,
  parameter int BIT_VEC_SIZE_LOG = 7,
  parameter int INPUTS = 2,
  parameter int LANE_W = (INPUTS > 1) ? $clog2(INPUTS) : 1
);
  logic [INPUTS-1:0][BIT_VEC_SIZE-1:0] in;
  logic [INPUTS-1:0] valid_in;
  logic [BIT_VEC_SIZE_LOG-1:0] id_out;
  logic [LANE_W-1:0] lane_out;
  logic last_out;
  logic valid_out;
  logic ready_in;
  logic overflow;
  logic busy;
`ifdef FP_DRAIN_COUNT_EN
  logic [BIT_VEC_SIZE_LOG:0] count_out;
  logic count_valid;
  modport master (
    input in, valid_in, ready_in,
    output id_out, lane_out, last_out, valid_out, overflow, busy, count_out, count_valid
  );
  modport slave (
    output in, valid_in, ready_in,
    input id_out, lane_out, last_out, valid_out, overflow, busy, count_out, count_valid
  );
`else
  modport master (
    input in, valid_in, ready_in,
    output id_out, lane_out, last_out, valid_out, overflow, busy
  );
  modport slave (
    output in, valid_in, ready_in,
    input id_out, lane_out, last_out, valid_out, overflow, busy
  );
`endif
endinterface

// File: rtl/fp_result_drain.sv
// fp_result_drain: buffers per-lane fp result vectors and serialises them into set-bit IDs.
// Ports: clk; rst (asynchronous, active-low); bus (fp_result_drain_if.master) carrying the
// lane inputs, the valid/ready ID stream, overflow and busy.
// Optional feature macro FP_DRAIN_COUNT_EN adds the per-vector popcount report
// (bus.count_out / bus.count_valid).
module fp_result_drain #(
  parameter int BIT_VEC_SIZE = 128,
  parameter int BIT_VEC_SIZE_LOG = 7,
  parameter int INPUTS = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LANE_W = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input logic clk,
  input logic rst,
  fp_result_drain_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, EMIT} state_t;
  typedef logic [BIT_VEC_SIZE-1:0] vec_t;
  state_t state_q, state_d;
  vec_t w_q, w_d;
  vec_t head;
  logic [LANE_W-1:0] lane_q, lane_d, rr_q, rr_d, sel;
  logic [LANE_W:0] idx;
  vec_t mem_q [INPUTS][FIFO_DEPTH];
  vec_t mem_d [INPUTS][FIFO_DEPTH];
  logic [AW:0] wr_q [INPUTS];
  logic [AW:0] wr_d [INPUTS];
  logic [AW:0] rd_q [INPUTS];
  logic [AW:0] rd_d [INPUTS];
  logic overflow_q, overflow_d;
  logic [INPUTS-1:0] empty, full, pop, push;
  logic any_ne, last;
  logic [BIT_VEC_SIZE_LOG-1:0] low_id;
  always_comb begin
    empty = '0;
    full = '0;
    for (int l = 0; l < INPUTS; l++) begin
      empty[l] = wr_q[l] == rd_q[l];
      full[l] = (wr_q[l] - rd_q[l]) == (AW+1)'(FIFO_DEPTH);
    end
  end
  // Round-robin pick: scan downward so the nearest non-empty lane at/after rr wins.
  always_comb begin
    sel = '0;
    any_ne = 1'b0;
    idx = '0;
    for (int k = INPUTS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (LANE_W+1)'(k);
      if (idx >= (LANE_W+1)'(INPUTS)) idx = idx - (LANE_W+1)'(INPUTS);
      if (!empty[idx[LANE_W-1:0]]) begin
        sel = idx[LANE_W-1:0];
        any_ne = 1'b1;
      end
    end
  end
  assign head = mem_q[sel][rd_q[sel][AW-1:0]];
  // A full FIFO still accepts when its head is popped on the same edge.
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    overflow_d = overflow_q;
    pop = '0;
    push = '0;
    for (int l = 0; l < INPUTS; l++) begin
      pop[l] = state_q == IDLE && any_ne && sel == LANE_W'(l);
      push[l] = bus.valid_in[l] && (!full[l] || pop[l]);
      if (pop[l]) rd_d[l] = rd_q[l] + (AW+1)'(1);
      if (push[l]) begin
        mem_d[l][wr_q[l][AW-1:0]] = bus.in[l];
        wr_d[l] = wr_q[l] + (AW+1)'(1);
      end
      if (bus.valid_in[l] && !push[l]) overflow_d = 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    lane_d = lane_q;
    rr_d = rr_q;
    last = (w_q & (w_q - vec_t'(1))) == '0;
    low_id = '0;
    for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) if (w_q[i]) low_id = BIT_VEC_SIZE_LOG'(i);
    if (state_q == IDLE && any_ne) begin
      state_d = EMIT;
      w_d = head;
      lane_d = sel;
      rr_d = (sel == LANE_W'(INPUTS - 1)) ? '0 : sel + LANE_W'(1);
    end else if (state_q == EMIT) begin
      if (w_q == '0) state_d = IDLE;
      else if (bus.ready_in) begin
        w_d = w_q & (w_q - vec_t'(1));
        state_d = last ? IDLE : EMIT;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      w_q <= '0;
      lane_q <= '0;
      rr_q <= '0;
      overflow_q <= 1'b0;
      for (int l = 0; l < INPUTS; l++) begin
        wr_q[l] <= '0;
        rd_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      lane_q <= lane_d;
      rr_q <= rr_d;
      overflow_q <= overflow_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign bus.valid_out = state_q == EMIT && w_q != '0;
  assign bus.id_out = low_id;
  assign bus.lane_out = lane_q;
  assign bus.last_out = bus.valid_out && last;
  assign bus.overflow = overflow_q;
  assign bus.busy = (~empty != '0) || state_q == EMIT;
`ifdef FP_DRAIN_COUNT_EN
  logic [BIT_VEC_SIZE_LOG:0] count_q, count_d, pc;
  logic count_valid_q, count_valid_d;
  // count_valid is registered, so it pulses in the cycle right after the vector finishes.
  always_comb begin
    pc = '0;
    for (int i = 0; i < BIT_VEC_SIZE; i++) pc = pc + (BIT_VEC_SIZE_LOG+1)'(head[i]);
    count_d = (state_q == IDLE && any_ne) ? pc : count_q;
    count_valid_d = state_q == EMIT && (w_q == '0 || (bus.ready_in && last));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      count_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      count_valid_q <= count_valid_d;
    end
  end
  assign bus.count_out = count_q;
  assign bus.count_valid = count_valid_q;
`endif
endmodule

// File: tb/tb_fp_result_drain.sv
// tb_fp_result_drain: directed and randomized checks of fp_result_drain against a queue model.
module tb_fp_result_drain;
  localparam int N = 128;
  localparam int LW = 7;
  localparam int NI = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fp_result_drain_if #(.BIT_VEC_SIZE(N), .BIT_VEC_SIZE_LOG(LW), .INPUTS(NI)) bus ();
  fp_result_drain #(.BIT_VEC_SIZE(N), .BIT_VEC_SIZE_LOG(LW), .INPUTS(NI), .FIFO_DEPTH(D))
    dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [NI][$];
  int sent [NI];
  int done [NI];
  int fired = 0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0, plane = 1'b0;
  logic [LW-1:0] pid = '0;
  task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // Model: each accepted non-zero vector contributes its set bits, ascending, to its lane queue.
  task automatic add_exp(input int l, input logic [N-1:0] v);
    int hi;
    hi = -1;
    for (int i = 0; i < N; i++) if (v[i]) hi = i;
    for (int i = 0; i < N; i++) if (v[i]) exp_q[l].push_back({i == hi, 7'(i)});
    if (hi >= 0) sent[l]++;
  endtask
  task automatic clear_model();
    for (int l = 0; l < NI; l++) begin
      exp_q[l].delete();
      sent[l] = 0;
      done[l] = 0;
    end
  endtask
  task automatic drive(input logic [1:0] vm, input logic [N-1:0] v0, input logic [N-1:0] v1,
                       input bit model);
    @(posedge clk);
    #1;
    bus.valid_in = vm;
    bus.in[0] = v0;
    bus.in[1] = v1;
    if (model && vm[0]) add_exp(0, v0);
    if (model && vm[1]) add_exp(1, v1);
  endtask
  task automatic idle_in();
    @(posedge clk);
    #1;
    bus.valid_in = '0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((bus.busy || exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_done"}, n < 1000, 1'b1);
    chk({tag, "_idle_after"}, bus.valid_out, 1'b0);
  endtask
  task automatic out_chk(input string tag, input logic v, input logic [LW-1:0] id,
                         input logic lane, input logic lst);
    chk({tag, "_valid"}, bus.valid_out, v);
    if (v) begin
      chk({tag, "_id"}, bus.id_out, id);
      chk({tag, "_lane"}, bus.lane_out, lane);
      chk({tag, "_last"}, bus.last_out, lst);
    end
  endtask
  // Stream monitor: every emitted ID must be the head of its lane queue; stalled outputs hold.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) pv = 1'b0;
    else begin
      if (pv && !pr) begin
        chk("hold_valid", bus.valid_out, 1'b1);
        chk("hold_id", bus.id_out, pid);
        chk("hold_lane", bus.lane_out, plane);
        chk("hold_last", bus.last_out, pl);
      end
      if (bus.valid_out) begin
        checks++;
        assert (exp_q[bus.lane_out].size() != 0) else begin
          errors++;
          $error("FAIL unexpected_id: observed lane %0d id %0d expected no output",
                 bus.lane_out, bus.id_out);
        end
        if (exp_q[bus.lane_out].size() != 0) begin
          e = exp_q[bus.lane_out][0];
          chk("stream_id", bus.id_out, e[6:0]);
          chk("stream_last", bus.last_out, e[7]);
          if (bus.ready_in) begin
            void'(exp_q[bus.lane_out].pop_front());
            fired++;
            if (bus.last_out) done[bus.lane_out]++;
          end
        end
      end
      pv = bus.valid_out;
      pr = bus.ready_in;
      pid = bus.id_out;
      plane = bus.lane_out;
      pl = bus.last_out;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int f0;
    logic [N-1:0] v;
    clear_model();
    bus.in = '0;
    bus.valid_in = '0;
    bus.ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_id", bus.id_out, 0);
    chk("rst_lane", bus.lane_out, 0);
    chk("rst_last", bus.last_out, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
`ifdef FP_DRAIN_COUNT_EN
    chk("rst_count", bus.count_out, 0);
    chk("rst_count_valid", bus.count_valid, 1'b0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    // 1: 0x112 on lane0 -> ids 1,4,8 from two cycles after the strobe
    drive(2'b01, 128'h112, '0, 1'b1);
    idle_in();
    @(negedge clk); out_chk("t1_lat", 1'b0, 0, 0, 0);
    @(negedge clk); out_chk("t1_a", 1'b1, 1, 0, 0);
    @(negedge clk); out_chk("t1_b", 1'b1, 4, 0, 0);
    @(negedge clk); out_chk("t1_c", 1'b1, 8, 0, 1);
    @(negedge clk); out_chk("t1_end", 1'b0, 0, 0, 0);
    chk("t1_busy", bus.busy, 1'b0);
    // 2: simultaneous lanes, rr from 0, one bubble between vectors
    do_reset();
    drive(2'b11, {1'b1, 127'b0}, 128'h1, 1'b1);
    idle_in();
    @(negedge clk); out_chk("t2_lat", 1'b0, 0, 0, 0);
    @(negedge clk); out_chk("t2_a", 1'b1, 127, 0, 1);
    @(negedge clk); out_chk("t2_bubble", 1'b0, 0, 0, 0);
    @(negedge clk); out_chk("t2_b", 1'b1, 0, 1, 1);
    @(negedge clk); out_chk("t2_end", 1'b0, 0, 0, 0);
    drive(2'b11, 128'h4, 128'h8, 1'b1);
    idle_in();
    @(negedge clk);
    @(negedge clk); out_chk("t2_rr", 1'b1, 2, 0, 1);
    drain("t2");
    // 3: backpressure hold then delivery
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    drive(2'b01, 128'h6, '0, 1'b1);
    idle_in();
    @(negedge clk); out_chk("t3_lat", 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); out_chk("t3_hold", 1'b1, 1, 0, 0);
    end
    @(posedge clk);
    #1;
    bus.ready_in = 1'b1;
    @(negedge clk); out_chk("t3_a", 1'b1, 1, 0, 0);
    @(negedge clk); out_chk("t3_b", 1'b1, 2, 0, 1);
    @(negedge clk); out_chk("t3_end", 1'b0, 0, 0, 0);
    // 4: overflow with six back-to-back vectors while stalled
    do_reset();
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    for (int k = 0; k < 6; k++) drive(2'b01, 128'(1) << (10 + k), '0, k < 5);
    idle_in();
    @(negedge clk);
    chk("t4_overflow", bus.overflow, 1'b1);
    chk("t4_busy", bus.busy, 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_overflow_sticky", bus.overflow, 1'b1);
    f0 = fired;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b1;
    drain("t4");
    chk("t4_drained_count", 32'(fired - f0), 5);
    chk("t4_overflow_kept", bus.overflow, 1'b1);
    // 5: zero vector discarded silently, then 0x1, then all-ones
    do_reset();
    drive(2'b10, '0, '0, 1'b1);
    drive(2'b10, '0, 128'h1, 1'b1);
    idle_in();
    @(negedge clk); out_chk("t5_zero_a", 1'b0, 0, 0, 0);
    @(negedge clk); out_chk("t5_zero_b", 1'b0, 0, 0, 0);
`ifdef FP_DRAIN_COUNT_EN
    chk("t5_cv_zero", bus.count_valid, 1'b1);
    chk("t5_count_zero", bus.count_out, 0);
`endif
    @(negedge clk); out_chk("t5_one", 1'b1, 0, 1, 1);
`ifdef FP_DRAIN_COUNT_EN
    chk("t5_count_one", bus.count_out, 1);
    @(negedge clk);
    chk("t5_cv_one", bus.count_valid, 1'b1);
    chk("t5_count_one_done", bus.count_out, 1);
`endif
    drive(2'b01, '1, '0, 1'b1);
    idle_in();
`ifdef FP_DRAIN_COUNT_EN
    begin
      int n;
      n = 0;
      while (!bus.count_valid && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("t5_cv_full_seen", n < 400, 1'b1);
      chk("t5_count_full", bus.count_out, N);
    end
`endif
    drain("t5");
    // 6: reset in the middle of a vector
    do_reset();
    drive(2'b01, 128'hF0, '0, 1'b1);
    idle_in();
    @(negedge clk);
    @(negedge clk); out_chk("t6_a", 1'b1, 4, 0, 0);
    @(negedge clk); out_chk("t6_b", 1'b1, 5, 0, 0);
    rst = 1'b0;
    clear_model();
    #1;
    chk("t6_rst_valid", bus.valid_out, 1'b0);
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_overflow", bus.overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_residue", bus.valid_out, 1'b0);
    end
    // Randomized traffic with random backpressure, kept below FIFO capacity
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      bus.ready_in = $urandom_range(0, 9) < 7;
      for (int l = 0; l < NI; l++) begin
        if ($urandom_range(0, 3) == 0 && sent[l] - done[l] < D) begin
          v = '0;
          repeat ($urandom_range(1, 4)) v[$urandom_range(0, N - 1)] = 1'b1;
          bus.in[l] = v;
          bus.valid_in[l] = 1'b1;
          add_exp(l, v);
        end else bus.valid_in[l] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.valid_in = '0;
    bus.ready_in = 1'b1;
    drain("rand");
    chk("rand_no_overflow", bus.overflow, 1'b0);
    chk("rand_lane0_done", 32'(done[0]), 32'(sent[0]));
    chk("rand_lane1_done", 32'(done[1]), 32'(sent[1]));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
